// File: rtl/survivor_mem.sv
// rtl/survivor_mem.sv - ping-pong survivor-path memory feeding the Viterbi traceback unit
// One bank fills with ACS decisions while the other is replayed in reverse order.
module survivor_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       dec_valid,
    input  logic [7:0] dec_in,
    output logic [7:0] d_out_0,
    output logic [7:0] d_out_1,
    output logic       selection,
    output logic       out_valid
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [7:0] mem0 [DEPTH];
    logic [7:0] mem1 [DEPTH];

    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          wr_bank_q, wr_bank_d;
    logic          primed_q, primed_d;
    logic [7:0]    d_out_0_q, d_out_0_d;
    logic [7:0]    d_out_1_q, d_out_1_d;
    logic          selection_q, selection_d;
    logic          out_valid_q, out_valid_d;

    logic          step;
    logic [AW-1:0] rd_addr;

    assign step    = enable & dec_valid;
    // Reads descend while writes ascend; even DEPTH keeps the two addresses apart.
    assign rd_addr = LAST_ADDR - wr_addr_q;

    always_comb begin
        wr_addr_d   = wr_addr_q;
        wr_bank_d   = wr_bank_q;
        primed_d    = primed_q;
        d_out_0_d   = d_out_0_q;
        d_out_1_d   = d_out_1_q;
        selection_d = selection_q;
        out_valid_d = 1'b0;
        if (!enable) begin
            wr_addr_d   = '0;
            wr_bank_d   = 1'b0;
            primed_d    = 1'b0;
            d_out_0_d   = 8'h00;
            d_out_1_d   = 8'h00;
            selection_d = 1'b0;
        end else if (dec_valid) begin
            d_out_0_d   = mem0[rd_addr];
            d_out_1_d   = mem1[rd_addr];
            selection_d = ~wr_bank_q;
            out_valid_d = primed_q;
            if (wr_addr_q == LAST_ADDR) begin
                wr_addr_d = '0;
                wr_bank_d = ~wr_bank_q;
                primed_d  = 1'b1;
            end else begin
                wr_addr_d = wr_addr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr_q   <= '0;
            wr_bank_q   <= 1'b0;
            primed_q    <= 1'b0;
            d_out_0_q   <= 8'h00;
            d_out_1_q   <= 8'h00;
            selection_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            wr_bank_q   <= wr_bank_d;
            primed_q    <= primed_d;
            d_out_0_q   <= d_out_0_d;
            d_out_1_q   <= d_out_1_d;
            selection_q <= selection_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Decision storage is deliberately unreset; a full fill re-primes after any clear.
    always_ff @(posedge clk) begin
        if (step) begin
            if (wr_bank_q) mem1[wr_addr_q] <= dec_in;
            else           mem0[wr_addr_q] <= dec_in;
        end
    end

    assign d_out_0   = d_out_0_q;
    assign d_out_1   = d_out_1_q;
    assign selection = selection_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_survivor_mem.sv
// tb/tb_survivor_mem.sv - directed self-checking bench for survivor_mem
// Both DEPTH=4 and DEPTH=16 instances share one stimulus stream.
module tb_survivor_mem;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       dec_valid = 1'b0;
    logic [7:0] dec_in = 8'h00;

    logic [7:0] d0_4, d1_4, d0_16, d1_16;
    logic       sel_4, ov_4, sel_16, ov_16;

    int n_checks = 0;
    int n_fail   = 0;

    survivor_mem #(.DEPTH(4), .AW(2)) u_dut4 (
        .clk(clk), .rst(rst), .enable(enable), .dec_valid(dec_valid), .dec_in(dec_in),
        .d_out_0(d0_4), .d_out_1(d1_4), .selection(sel_4), .out_valid(ov_4)
    );

    survivor_mem #(.DEPTH(16), .AW(4)) u_dut16 (
        .clk(clk), .rst(rst), .enable(enable), .dec_valid(dec_valid), .dec_in(dec_in),
        .d_out_0(d0_16), .d_out_1(d1_16), .selection(sel_16), .out_valid(ov_16)
    );

    always #5 clk = ~clk;

    task automatic do_step(input logic [7:0] d);
        @(negedge clk);
        enable    = 1'b1;
        dec_valid = 1'b1;
        dec_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_idle();
        @(negedge clk);
        dec_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ov_4, sel_4, d0_4, d1_4} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_d4: got ov=%b sel=%b d0=%h d1=%h, want all 0", ov_4, sel_4, d0_4, d1_4);
        end
        n_checks++;
        if ({ov_16, sel_16, d0_16, d1_16} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_d16: got ov=%b sel=%b d0=%h d1=%h, want all 0", ov_16, sel_16, d0_16, d1_16);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_step(8'h10 + 8'(i));
            n_checks++;
            if (ov_4 !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_no_valid step %0d: got ov=%b, want 0", i, ov_4);
            end
        end
    endtask

    task automatic test_first_replay();
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin
            do_step(8'h20 + 8'(i));
            e = 8'h13 - 8'(i);
            n_checks++;
            if ({ov_4, sel_4, d0_4} !== {1'b1, 1'b0, e}) begin
                n_fail++;
                $display("FAIL first_replay %0d: got ov=%b sel=%b d0=%h, want ov=1 sel=0 d0=%h", i, ov_4, sel_4, d0_4, e);
            end
        end
    endtask

    task automatic test_bank_switch();
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin
            do_step(8'h30 + 8'(i));
            e = 8'h23 - 8'(i);
            n_checks++;
            if ({ov_4, sel_4, d1_4} !== {1'b1, 1'b1, e}) begin
                n_fail++;
                $display("FAIL bank_switch %0d: got ov=%b sel=%b d1=%h, want ov=1 sel=1 d1=%h", i, ov_4, sel_4, d1_4, e);
            end
        end
    endtask

    task automatic test_bubbles();
        logic [7:0] e;
        for (int i = 0; i < 4; i++) begin
            do_step(8'h40 + 8'(i));
            e = 8'h33 - 8'(i);
            n_checks++;
            if ({ov_4, sel_4, d0_4} !== {1'b1, 1'b0, e}) begin
                n_fail++;
                $display("FAIL bubble_step %0d: got ov=%b sel=%b d0=%h, want ov=1 sel=0 d0=%h", i, ov_4, sel_4, d0_4, e);
            end
            if (i < 3) begin
                for (int k = 0; k < 2; k++) begin
                    do_idle();
                    n_checks++;
                    if ({ov_4, sel_4, d0_4} !== {1'b0, 1'b0, e}) begin
                        n_fail++;
                        $display("FAIL bubble_idle %0d.%0d: got ov=%b sel=%b d0=%h, want ov=0 sel=0 d0=%h", i, k, ov_4, sel_4, d0_4, e);
                    end
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            do_step(8'h50 + 8'(i));
            e = 8'h43 - 8'(i);
            n_checks++;
            if ({ov_4, sel_4, d1_4} !== {1'b1, 1'b1, e}) begin
                n_fail++;
                $display("FAIL pre_drop %0d: got ov=%b sel=%b d1=%h, want ov=1 sel=1 d1=%h", i, ov_4, sel_4, d1_4, e);
            end
        end
        @(negedge clk);
        enable    = 1'b0;
        dec_valid = 1'b1;
        dec_in    = 8'hAA;
        @(posedge clk);
        #1;
        n_checks++;
        if ({ov_4, sel_4, d0_4, d1_4} !== 18'h0) begin
            n_fail++;
            $display("FAIL enable_drop_clear: got ov=%b sel=%b d0=%h d1=%h, want all 0", ov_4, sel_4, d0_4, d1_4);
        end
        for (int i = 0; i < 4; i++) begin
            do_step(8'h60 + 8'(i));
            n_checks++;
            if (ov_4 !== 1'b0) begin
                n_fail++;
                $display("FAIL refill_no_valid %0d: got ov=%b, want 0", i, ov_4);
            end
        end
        for (int i = 0; i < 2; i++) begin
            do_step(8'h70 + 8'(i));
            e = 8'h63 - 8'(i);
            n_checks++;
            if ({ov_4, sel_4, d0_4} !== {1'b1, 1'b0, e}) begin
                n_fail++;
                $display("FAIL replay_after_drop %0d: got ov=%b sel=%b d0=%h, want ov=1 sel=0 d0=%h", i, ov_4, sel_4, d0_4, e);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        dec_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({ov_4, sel_4, d0_4, d1_4} !== 18'h0) begin
            n_fail++;
            $display("FAIL async_reset: got ov=%b sel=%b d0=%h d1=%h, want all 0 before edge", ov_4, sel_4, d0_4, d1_4);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_depth16();
        for (int i = 0; i < 16; i++) begin
            do_step(8'h80 + 8'(i));
            n_checks++;
            if (ov_16 !== 1'b0) begin
                n_fail++;
                $display("FAIL d16_fill %0d: got ov=%b, want 0", i, ov_16);
            end
        end
        do_step(8'h90);
        n_checks++;
        if ({ov_16, sel_16, d0_16} !== {1'b1, 1'b0, 8'h8F}) begin
            n_fail++;
            $display("FAIL d16_step17: got ov=%b sel=%b d0=%h, want ov=1 sel=0 d0=8f", ov_16, sel_16, d0_16);
        end
        do_step(8'h91);
        n_checks++;
        if ({ov_16, sel_16, d0_16} !== {1'b1, 1'b0, 8'h8E}) begin
            n_fail++;
            $display("FAIL d16_step18: got ov=%b sel=%b d0=%h, want ov=1 sel=0 d0=8e", ov_16, sel_16, d0_16);
        end
    endtask

    task automatic test_enable_at_last();
        @(negedge clk);
        enable    = 1'b0;
        dec_valid = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) do_step(8'hB0 + 8'(i));
        @(negedge clk);
        enable    = 1'b0;
        dec_valid = 1'b1;
        dec_in    = 8'hB3;
        @(posedge clk);
        #1;
        n_checks++;
        if (ov_4 !== 1'b0) begin
            n_fail++;
            $display("FAIL last_write_clear: got ov=%b, want 0", ov_4);
        end
        for (int i = 0; i < 4; i++) begin
            do_step(8'hC0 + 8'(i));
            n_checks++;
            if (ov_4 !== 1'b0) begin
                n_fail++;
                $display("FAIL not_primed %0d: got ov=%b, want 0", i, ov_4);
            end
        end
        do_step(8'hD0);
        n_checks++;
        if ({ov_4, sel_4, d0_4} !== {1'b1, 1'b0, 8'hC3}) begin
            n_fail++;
            $display("FAIL primed_after_refill: got ov=%b sel=%b d0=%h, want ov=1 sel=0 d0=c3", ov_4, sel_4, d0_4);
        end
    endtask

    initial begin
        test_reset();
        test_first_replay();
        test_bank_switch();
        test_bubbles();
        test_enable_drop();
        test_async_reset();
        test_depth16();
        test_enable_at_last();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end
endmodule
